fir_cfg_ctrl: RTL and testbench

AXI-Lite configuration and sequencing controller for the FIR engine. It holds ap_ctrl, data_length and tap_num, and issues the start pulse to the engine. It shares the single tap-RAM port (bram32) between the AXI-Lite host and the FIR datapath, and tracks ap_start/ap_done/ap_idle across a run.

---
 rtl/fir_ctrl_pkg.sv | 29 ++
 rtl/fir_axil_rd.sv | 89 ++++++++
 rtl/fir_cfg_ctrl.sv | 142 ++++++++++++++
 tb/tb_fir_cfg_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// rtl/fir_ctrl_pkg.sv - shared register map, status bits and read-FSM states for the FIR controller
package fir_ctrl_pkg;

  // Byte offsets in the AXI-Lite register map
  localparam logic [31:0] ADDR_AP_CTRL  = 32'h0000_0000;
  localparam logic [31:0] ADDR_DLEN     = 32'h0000_0010;
  localparam logic [31:0] ADDR_TNUM     = 32'h0000_0014;
  localparam logic [31:0] ADDR_TAP_BASE = 32'h0000_0080;

  // ap_ctrl bit positions
  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

  // Returned for host tap reads while the engine owns the RAM port
  localparam logic [31:0] BUSY_READ_VAL = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rd_state_t;

  // True when a zero-extended byte address falls inside the coefficient window
  function automatic logic in_tap_window(input logic [31:0] addr, input logic [31:0] tap_bytes);
    return (addr >= ADDR_TAP_BASE) && (addr < (ADDR_TAP_BASE + tap_bytes));
  endfunction

endpackage

// File: rtl/fir_axil_rd.sv
// rtl/fir_axil_rd.sv - AXI-Lite read channel: accept, one wait cycle for the tap RAM, then hold rdata
module fir_axil_rd
  import fir_ctrl_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   arvalid,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   arready,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ar_block,
  input  logic                   busy,
  input  logic [pDATA_WIDTH-1:0] ap_ctrl_val,
  input  logic [pDATA_WIDTH-1:0] data_length,
  input  logic [pDATA_WIDTH-1:0] tap_num,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   rd_tap_req,
  output logic [pADDR_WIDTH-1:0] rd_tap_addr
);

  localparam logic [31:0] TAP_BYTES = 32'(4 * Tape_Num);

  rd_state_t              state;
  logic [31:0]            ar_ext;
  logic                   ar_in_tap;
  logic [31:0]            addr_q;
  logic                   is_tap_q;
  logic                   busy_q;
  logic [pDATA_WIDTH-1:0] reg_val;

  assign ar_ext    = 32'(araddr);
  assign ar_in_tap = in_tap_window(ar_ext, TAP_BYTES);

  // Accept only from idle, and yield to a tap write that owns the RAM this cycle
  assign arready     = axis_rst_n && (state == R_IDLE) && arvalid && !ar_block;
  assign rd_tap_req  = arready && ar_in_tap && !busy;
  assign rd_tap_addr = pADDR_WIDTH'(ar_ext - ADDR_TAP_BASE);

  // Register-side read value for the latched address; unmapped reads return zero
  always_comb begin
    reg_val = '0;
    if (addr_q == ADDR_AP_CTRL)   reg_val = ap_ctrl_val;
    else if (addr_q == ADDR_DLEN) reg_val = data_length;
    else if (addr_q == ADDR_TNUM) reg_val = tap_num;
  end

  // Read FSM: latch the request, capture RAM or register data, then hold until rready
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state    <= R_IDLE;
      rvalid   <= 1'b0;
      rdata    <= '0;
      addr_q   <= '0;
      is_tap_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        R_IDLE: begin
          if (arready) begin
            addr_q   <= ar_ext;
            is_tap_q <= ar_in_tap;
            busy_q   <= busy;
            state    <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (is_tap_q) rdata <= busy_q ? pDATA_WIDTH'(BUSY_READ_VAL) : tap_Do;
          else          rdata <= reg_val;
          rvalid <= 1'b1;
          state  <= R_DATA;
        end
        R_DATA: begin
          if (rready) begin
            rvalid <= 1'b0;
            state  <= R_IDLE;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fir_cfg_ctrl.sv
// rtl/fir_cfg_ctrl.sv - FIR configuration registers, start/done sequencing and tap-RAM port sharing
module fir_cfg_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   eng_start,
  output logic [pDATA_WIDTH-1:0] eng_data_len,
  output logic [pDATA_WIDTH-1:0] eng_tap_num,
  input  logic                   eng_tap_en,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  output logic [pDATA_WIDTH-1:0] eng_tap_Do,
  input  logic                   eng_done
);

  localparam logic [31:0] TAP_BYTES = 32'(4 * Tape_Num);

  logic                   ap_start, ap_done, ap_idle;
  logic [pDATA_WIDTH-1:0] data_length, tap_num, ap_ctrl_val;
  logic [31:0]            aw_ext;
  logic                   wr_hs, tap_wr_commit, start_acc;
  logic                   rd_tap_req;
  logic [pADDR_WIDTH-1:0] rd_tap_addr;

  assign aw_ext        = 32'(awaddr);
  assign wr_hs         = axis_rst_n && awvalid && wvalid;
  assign awready       = wr_hs;
  assign wready        = wr_hs;
  assign tap_wr_commit = wr_hs && ap_idle && in_tap_window(aw_ext, TAP_BYTES);
  assign start_acc     = wr_hs && ap_idle && (aw_ext == ADDR_AP_CTRL) && wdata[AP_START_BIT];

  assign eng_data_len = data_length;
  assign eng_tap_num  = tap_num;
  assign eng_tap_Do   = tap_Do;

  // Assemble the ap_ctrl read word from the status bits
  always_comb begin
    ap_ctrl_val               = '0;
    ap_ctrl_val[AP_START_BIT] = ap_start;
    ap_ctrl_val[AP_DONE_BIT]  = ap_done;
    ap_ctrl_val[AP_IDLE_BIT]  = ap_idle;
  end

  // Tap RAM port: engine while busy, otherwise host write first, then host read
  always_comb begin
    tap_WE = 4'h0;
    tap_EN = 1'b0;
    tap_A  = '0;
    tap_Di = '0;
    if (axis_rst_n) begin
      if (!ap_idle) begin
        tap_EN = eng_tap_en;
        tap_A  = eng_tap_A;
      end else if (tap_wr_commit) begin
        tap_EN = 1'b1;
        tap_WE = 4'hF;
        tap_A  = pADDR_WIDTH'(aw_ext - ADDR_TAP_BASE);
        tap_Di = wdata;
      end else if (rd_tap_req) begin
        tap_EN = 1'b1;
        tap_A  = rd_tap_addr;
      end
    end
  end

  // Run configuration is frozen while the engine is busy
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      data_length <= '0;
      tap_num     <= '0;
    end else if (wr_hs && ap_idle) begin
      if (aw_ext == ADDR_DLEN) data_length <= wdata;
      if (aw_ext == ADDR_TNUM) tap_num     <= wdata;
    end
  end

  // Start/done sequencing; a done pulse is only meaningful while a run is in progress
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      ap_start  <= 1'b0;
      ap_done   <= 1'b0;
      ap_idle   <= 1'b1;
      eng_start <= 1'b0;
    end else begin
      eng_start <= start_acc;
      if (eng_start) ap_start <= 1'b0;
      if (eng_done && !ap_idle) begin
        ap_done <= 1'b1;
        ap_idle <= 1'b1;
      end else if (start_acc) begin
        ap_start <= 1'b1;
        ap_done  <= 1'b0;
        ap_idle  <= 1'b0;
      end
    end
  end

  fir_axil_rd #(
    .pADDR_WIDTH(pADDR_WIDTH),
    .pDATA_WIDTH(pDATA_WIDTH),
    .Tape_Num   (Tape_Num)
  ) u_rd (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .arvalid    (arvalid),
    .araddr     (araddr),
    .arready    (arready),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .ar_block   (tap_wr_commit && in_tap_window(32'(araddr), TAP_BYTES)),
    .busy       (!ap_idle),
    .ap_ctrl_val(ap_ctrl_val),
    .data_length(data_length),
    .tap_num    (tap_num),
    .tap_Do     (tap_Do),
    .rd_tap_req (rd_tap_req),
    .rd_tap_addr(rd_tap_addr)
  );

endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// tb/tb_fir_cfg_ctrl.sv - scoreboard bench for fir_cfg_ctrl with a behavioural register/RAM model
module tb_fir_cfg_ctrl;

  localparam int Tape_Num = 32;

  logic        axis_clk, axis_rst_n;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr, tap_A, eng_tap_A;
  logic [31:0] wdata, rdata, tap_Di, tap_Do, eng_data_len, eng_tap_num, eng_tap_Do;
  logic [3:0]  tap_WE;
  logic        tap_EN, eng_start, eng_tap_en, eng_done;

  fir_cfg_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(Tape_Num)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .eng_start(eng_start), .eng_data_len(eng_data_len), .eng_tap_num(eng_tap_num),
    .eng_tap_en(eng_tap_en), .eng_tap_A(eng_tap_A), .eng_tap_Do(eng_tap_Do),
    .eng_done(eng_done)
  );

  initial begin
    axis_clk = 1'b0;
    forever #5 axis_clk = ~axis_clk;
  end

  int cyc = 0;
  always @(posedge axis_clk) cyc <= cyc + 1;

  // Tap RAM attached to the DUT port: synchronous, read-before-write
  logic [31:0] ram [0:1023];
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      tap_Do <= ram[tap_A[11:2]];
      if (tap_WE == 4'hF) ram[tap_A[11:2]] <= tap_Di;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Behavioural model of the host-visible state
  logic [31:0] m_mem [Tape_Num];
  logic [31:0] m_dlen = 0, m_tnum = 0;
  bit          m_idle = 1, m_done = 0;

  function automatic bit is_tap(input logic [11:0] a);
    return int'(a) >= 128 && int'(a) < 128 + 4 * Tape_Num;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (a == 12'h000) return {29'd0, m_idle, m_done, 1'b0};
    if (a == 12'h010) return m_dlen;
    if (a == 12'h014) return m_tnum;
    if (is_tap(a)) return m_idle ? m_mem[(int'(a) - 128) / 4] : 32'hFFFF_FFFF;
    return 32'd0;
  endfunction

  // Scoreboard of expected read responses
  typedef struct {
    logic [31:0] data;
    int          hs;
    logic [11:0] addr;
  } rd_exp_t;
  rd_exp_t exp_q[$];
  bit      first_seen = 0;
  bit      rand_rdy   = 0;

  // Monitor: check first-rvalid latency and the data at each R handshake
  always @(negedge axis_clk) begin
    if (axis_rst_n && rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got rvalid with rdata %h expected no response", rdata);
      end else begin
        if (!first_seen) begin
          chk("rd_latency", 32'(cyc), 32'(exp_q[0].hs + 2));
          first_seen = 1;
        end
        if (rready) begin
          chk($sformatf("rdata@%h", exp_q[0].addr), rdata, exp_q[0].data);
          void'(exp_q.pop_front());
          first_seen = 0;
        end
      end
    end
  end

  initial begin
    rready = 1'b1;
    forever begin
      @(posedge axis_clk);
      #1;
      rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    bit start_acc;
    start_acc = (a == 12'h000) && d[0] && m_idle;
    @(posedge axis_clk); #1;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d;
    @(negedge axis_clk);
    chk("awready", 32'(awready), 32'd1);
    chk("wready", 32'(wready), 32'd1);
    if (is_tap(a)) begin
      if (m_idle) begin
        chk("wr_tap_EN", 32'(tap_EN), 32'd1);
        chk("wr_tap_WE", 32'(tap_WE), 32'hF);
        chk("wr_tap_A", 32'(tap_A), 32'(int'(a) - 128));
        chk("wr_tap_Di", tap_Di, d);
      end else begin
        chk("busy_tap_WE", 32'(tap_WE), 32'd0);
      end
    end
    if (a == 12'h000 && d[0] && m_idle) begin
      m_idle = 0; m_done = 0;
    end else if (m_idle && a == 12'h010) m_dlen = d;
    else if (m_idle && a == 12'h014) m_tnum = d;
    else if (m_idle && is_tap(a)) m_mem[(int'(a) - 128) / 4] = d;
    @(posedge axis_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge axis_clk);
    chk("eng_start_pulse", 32'(eng_start), 32'(start_acc));
    if (start_acc) begin
      @(negedge axis_clk);
      chk("eng_start_end", 32'(eng_start), 32'd0);
    end
  endtask

  task automatic do_read(input logic [11:0] a);
    logic [31:0] e;
    bit got;
    e = model_read(a);
    got = 0;
    @(posedge axis_clk); #1;
    arvalid = 1'b1; araddr = a;
    for (int i = 0; i < 60; i++) begin
      @(negedge axis_clk);
      if (arready) begin
        got = 1;
        exp_q.push_back('{data: e, hs: cyc, addr: a});
        break;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ar_timeout: got no arready expected handshake for %h", a);
    end
    @(posedge axis_clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge axis_clk);
      if (exp_q.size() == 0 && !rvalid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_done();
    @(posedge axis_clk); #1;
    eng_done = 1'b1;
    if (!m_idle) begin
      m_idle = 1; m_done = 1;
    end
    @(posedge axis_clk); #1;
    eng_done = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, 32'(awready), 32'd0);
    chk({tag, "_wready"}, 32'(wready), 32'd0);
    chk({tag, "_arready"}, 32'(arready), 32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_tap_WE"}, 32'(tap_WE), 32'd0);
    chk({tag, "_tap_EN"}, 32'(tap_EN), 32'd0);
    chk({tag, "_tap_A"}, 32'(tap_A), 32'd0);
    chk({tag, "_tap_Di"}, tap_Di, 32'd0);
    chk({tag, "_eng_start"}, 32'(eng_start), 32'd0);
    chk({tag, "_eng_data_len"}, eng_data_len, 32'd0);
    chk({tag, "_eng_tap_num"}, eng_tap_num, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] v, old84;
    logic [11:0] a;
    int          op;
    axis_rst_n = 1'b0;
    awvalid = 0; wvalid = 0; arvalid = 0; eng_tap_en = 0; eng_done = 0;
    awaddr = 0; araddr = 0; wdata = 0; eng_tap_A = 0;
    repeat (3) @(posedge axis_clk);
    @(negedge axis_clk);
    chk_reset_outputs("rst");
    @(posedge axis_clk); #1;
    axis_rst_n = 1'b1;

    do_read(12'h000);
    do_read(12'h010);
    drain();

    do_write(12'h010, 32'd400);
    do_write(12'h014, 32'd32);
    for (int k = 0; k < Tape_Num; k++) do_write(12'(128 + 4 * k), $urandom);
    for (int k = 0; k < Tape_Num; k++) do_read(12'(128 + 4 * k));
    drain();
    chk("eng_data_len", eng_data_len, 32'd400);
    chk("eng_tap_num", eng_tap_num, 32'd32);

    rand_rdy = 1;
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 5));
      case (op)
        0: a = 12'h010;
        1: a = 12'h014;
        2: a = 12'h004;
        3: a = 12'h100;
        default: a = 12'(128 + 4 * int'($urandom_range(0, Tape_Num - 1)));
      endcase
      if ($urandom_range(0, 1) == 0) do_read(a);
      else do_write(a, $urandom);
    end
    do_read(12'h000);
    do_read(12'hFFC);
    drain();
    rand_rdy = 0;

    do_write(12'h010, 32'd400);
    do_write(12'h000, 32'd1);
    repeat (5) @(posedge axis_clk);
    do_read(12'h000);
    do_write(12'h010, 32'd999);
    do_read(12'h010);
    do_read(12'h084);
    drain();
    old84 = m_mem[1];
    do_write(12'h084, 32'hDEAD_BEEF);
    do_write(12'h000, 32'd1);
    @(posedge axis_clk); #1;
    eng_tap_en = 1'b1; eng_tap_A = 12'h010;
    @(negedge axis_clk);
    chk("eng_own_tap_EN", 32'(tap_EN), 32'd1);
    chk("eng_own_tap_A", 32'(tap_A), 32'h010);
    chk("eng_own_tap_WE", 32'(tap_WE), 32'd0);
    @(posedge axis_clk); #1;
    eng_tap_en = 1'b0;
    @(negedge axis_clk);
    chk("eng_tap_Do", eng_tap_Do, m_mem[4]);
    chk("eng_data_len_run", eng_data_len, 32'd400);
    pulse_done();
    do_read(12'h000);
    do_read(12'h084);
    drain();
    chk("coef84_kept", m_mem[1], old84);

    do_write(12'h000, 32'd1);
    repeat (5) @(posedge axis_clk);
    do_read(12'h000);
    drain();
    pulse_done();
    do_read(12'h000);
    drain();

    v = $urandom;
    @(posedge axis_clk); #1;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h088; wdata = v;
    arvalid = 1'b1; araddr = 12'h088;
    @(negedge axis_clk);
    chk("coll_awready", 32'(awready), 32'd1);
    chk("coll_arready", 32'(arready), 32'd0);
    chk("coll_tap_WE", 32'(tap_WE), 32'hF);
    m_mem[2] = v;
    @(posedge axis_clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge axis_clk);
    chk("coll_arready_next", 32'(arready), 32'd1);
    if (arready) exp_q.push_back('{data: v, hs: cyc, addr: 12'h088});
    @(posedge axis_clk); #1;
    arvalid = 1'b0;
    drain();

    do_write(12'h014, 32'd7);
    do_read(12'h014);
    drain();
    do_write(12'h000, 32'd1);
    @(posedge axis_clk); #1;
    eng_tap_en = 1'b1; eng_tap_A = 12'h020;
    @(negedge axis_clk);
    chk("pre_rst_tap_EN", 32'(tap_EN), 32'd1);
    #2;
    axis_rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    eng_tap_en = 1'b0;
    m_idle = 1; m_done = 0; m_dlen = 0; m_tnum = 0;
    @(posedge axis_clk); #1;
    axis_rst_n = 1'b1;
    do_read(12'h000);
    do_read(12'h010);
    do_read(12'h014);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
